// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared state encoding and frame constants for the FIFO UART TX.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  localparam logic       START_BIT    = 1'b0;
  localparam logic       STOP_BIT     = 1'b1;
  localparam int         DATA_BITS    = 8;
  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
//------------------------------------------------------------------------------
// uart_baud_counter : counts 0..CLKS_PER_BIT-1, pulses bit_done on the last
//                     cycle of every bit period.
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // clear wins so the count always restarts at 0 on the first cycle of a frame
  assign bit_done = !clear && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
//------------------------------------------------------------------------------
// fifo_uart_tx : pops bytes from a FIFO and serialises them as 8N1 UART frames
//                (8E1 when FIFO_UART_TX_PARITY_EN is defined).
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       baud_clear;
  logic       bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Outputs depend only on state and registers, never on the FIFO inputs.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    baud_clear = 1'b1;
    fifo_pop   = 1'b0;
    tx         = STOP_BIT;
    busy       = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (!fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        fifo_pop = 1'b1;
        state_d  = LATCH;
      end
      LATCH: begin
        shift_d   = fifo_data;
        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^fifo_data;
`endif
        state_d   = START;
      end
      START: begin
        baud_clear = 1'b0;
        tx         = START_BIT;
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        baud_clear = 1'b0;
        tx         = shift_q[0];
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        baud_clear = 1'b0;
        tx         = parity_q;
        if (bit_done) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        baud_clear = 1'b0;
        tx         = STOP_BIT;
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
//------------------------------------------------------------------------------
// tb_fifo_uart_tx : self-checking bench for fifo_uart_tx (CLKS_PER_BIT = 4).
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_uart_tx;

  localparam int N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int F   = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int F   = 10;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_pop, tx, busy;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int underflows = 0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read side: data valid the cycle after the pop strobe
  always @(posedge clk) begin
    if (fifo_pop) begin
      pops <= pops + 1;
      if (wr_ptr == rd_ptr) begin
        underflows <= underflows + 1;
      end else begin
        fifo_data <= mem[rd_ptr & 255];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [0:9] seq;
    logic       par;
  } vec_t;

  vec_t vecs [0:6];

  int         S [0:63];
  logic [7:0] D [0:63];
  int         nb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic etx, input logic epop, input logic ebusy);
    chk({tag, ".tx"}, {31'd0, tx}, {31'd0, etx});
    chk({tag, ".pop"}, {31'd0, fifo_pop}, {31'd0, epop});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr & 255] = d;
    wr_ptr++;
  endtask

  function automatic logic exp_bit(input logic [0:9] seq, input logic par, input int b);
    if (PAR && b == 9) return par;
    if (PAR && b == 10) return seq[9];
    return seq[b];
  endfunction

  // Byte already visible in the FIFO and DUT idle at the current negedge.
  task automatic run_frame(input string tag, input logic [0:9] seq, input logic par);
    step(); chk_out({tag, ".popcyc"}, 1'b1, 1'b1, 1'b1);
    step(); chk_out({tag, ".latch"}, 1'b1, 1'b0, 1'b1);
    for (int b = 0; b < F; b++) begin
      for (int j = 0; j < N; j++) begin
        step();
        chk_out($sformatf("%s.bit%0d", tag, b), exp_bit(seq, par, b), 1'b0, 1'b1);
      end
    end
    step(); chk_out({tag, ".done"}, 1'b1, 1'b0, 1'b0);
  endtask

  // Reference: frame n occupies cycles S[n] .. S[n]+F*N-1, pop two cycles earlier.
  function automatic logic model_tx(input int c);
    for (int n = 0; n < nb; n++) begin
      if (c >= S[n] && c < S[n] + F * N) begin
        int b;
        b = (c - S[n]) / N;
        if (b == 0) return 1'b0;
        if (b <= 8) return D[n][b-1];
        if (PAR && b == 9) return ^D[n];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic model_busy(input int c);
    for (int n = 0; n < nb; n++) begin
      if (c >= S[n] - 2 && c < S[n] + F * N) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic model_pop(input int c);
    for (int n = 0; n < nb; n++) begin
      if (c == S[n] - 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic rand_check();
    chk_out("rnd", model_tx(cyc), model_pop(cyc), model_busy(cyc));
  endtask

  logic tr_tx [0:127];

  initial begin
    int np;
    int a;
    int b;
    int lows;
    int last_end;
    int gap;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[2] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[4] = '{8'h03, 10'b0110000001, 1'b0};
    vecs[5] = '{8'h80, 10'b0000000011, 1'b1};
    vecs[6] = '{8'h3C, 10'b0001111001, 1'b0};

    // Reset held with a byte waiting: nothing may move
    push(8'h5A);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("reset", 1'b1, 1'b0, 1'b0);
    end
    reset = 1'b0;
    #1;
    chk_out("release", 1'b1, 1'b0, 1'b0);
    run_frame("rstbyte", 10'b0010110101, 1'b0);

    // Empty FIFO: line must stay idle
    np = pops;
    for (int i = 0; i < 100; i++) begin
      step();
      chk_out("empty", 1'b1, 1'b0, 1'b0);
    end
    chk("empty.pops", pops - np, 0);

    // Table of single-byte frames
    for (int v = 0; v < 7; v++) begin
      push(vecs[v].data);
      run_frame($sformatf("vec%0h", vecs[v].data), vecs[v].seq, vecs[v].par);
    end

    // Back-to-back: 0x00 then 0xFF queued together
    np = pops;
    push(8'h00);
    push(8'hFF);
    for (int i = 0; i < 2 * F * N + 12; i++) begin
      step();
      tr_tx[i] = tx;
    end
    chk("b2b.pops", pops - np, 2);
    a = -1;
    for (int i = 0; i < 2 * F * N + 12; i++) begin
      if (a < 0 && tr_tx[i] == 1'b0) a = i;
    end
    chk("b2b.first_start", a, 2);
    b = -1;
    if (a >= 0) begin
      for (int i = a + F * N; i < 2 * F * N + 12; i++) begin
        if (b < 0 && tr_tx[i] == 1'b0) b = i;
      end
    end
    chk("b2b.idle_gap", b - (a + F * N), 3);
    lows = 0;
    if (b >= 0) begin
      for (int i = b; i < b + F * N && i < 2 * F * N + 12; i++) begin
        if (tr_tx[i] == 1'b0) lows++;
      end
    end
    chk("b2b.ff_lows", lows, PAR ? 2 * N : N);
    step();
    chk_out("b2b.end", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of data bit 3 of 0x3C
    np = pops;
    push(8'h3C);
    for (int i = 0; i < 2 + N + 3 * N + 2; i++) step();
    chk("mid.bit3", {31'd0, tx}, 32'd1);
    chk("mid.busy_before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1 chk_out("mid.rst", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("mid.hold", 1'b1, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      chk_out("mid.after", 1'b1, 1'b0, 1'b0);
    end
    chk("mid.pops", pops - np, 1);
    chk("mid.empty", {31'd0, fifo_empty}, 32'd1);

    // Randomised traffic against the frame-timing reference
    last_end = cyc;
    for (int n = 0; n < 20; n++) begin
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 50));
      for (int g = 0; g < gap; g++) begin
        step();
        rand_check();
      end
      d = 8'($urandom);
      push(d);
      D[nb] = d;
      S[nb] = ((cyc > last_end) ? cyc : last_end) + 3;
      last_end = S[nb] + F * N;
      nb++;
    end
    while (cyc < last_end + 5) begin
      step();
      rand_check();
    end
    chk("underflow", underflows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Consumer end of the 8-bit byte FIFO: pops bytes whenever the FIFO is non-empty and serialises each one as an 8N1 UART frame on a single TX pin.
- Sits between the FIFO's pop/data_out/empty side and the board UART pad on the ECP5 design.
- Gives the FIFO a real reader, so host-bound data can be buffered and drained at line rate.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200). Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO read data; valid the cycle after fifo_pop is high.
- fifo_pop  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high from POP through the end of STOP.

Behaviour:
- Reset (async, immediate): state IDLE; tx=1, fifo_pop=0, busy=0; baud counter, bit index and shift register cleared.
- Reset mid-frame: tx returns high immediately; the byte in flight is dropped and not re-popped.
- All outputs are registered or Moore outputs of the state; none depend combinationally on inputs.
- Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE: tx=1, busy=0. Next state is POP if fifo_empty==0, else stay in IDLE.
  - POP (1 cycle): fifo_pop=1, busy=1. Next state LATCH.
  - LATCH (1 cycle): shift register <= fifo_data. Next state START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shift[0]. After CLKS_PER_BIT cycles, shift right and increment bit index. After bit 7 completes, next state STOP (or PARITY when PARITY_EN is defined).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency: first tx falling edge occurs 3 cycles after the first IDLE cycle that sees fifo_empty==0.
- Back-to-back bytes: minimum line idle between stop end and next start is 3 cycles (IDLE, POP, LATCH). No pop is issued while busy.
- fifo_empty is sampled only in IDLE. Data arriving mid-frame waits for the next IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Bit index is 3 bits.
- fifo_pop is never asserted while fifo_empty==1 is sampled in IDLE, so underflow is impossible from this side.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 8E1 frame of 11 bits.
- Undefined: 8N1 frame of 10 bits; no parity state or logic.

Decomposition:
- Package uart_pkg: state enum (IDLE, POP, LATCH, START, DATA, PARITY, STOP), START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8.
- One sub-module: uart_baud_counter. Parameter CLKS_PER_BIT; inputs clk, reset, clear; output bit_done, a one-cycle pulse on the last cycle of each bit.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset check: assert reset with fifo_empty=0 -> tx=1, fifo_pop=0, busy=0; no pop during reset or in the first cycle after release until IDLE samples fifo_empty.
- Single byte: one byte 0xA5, fifo_empty deasserts once -> fifo_pop high exactly 1 cycle; tx low 3 cycles later; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy falls after stop.
- Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_pop never asserted, tx constant 1.
- Back-to-back: bytes 0x00 then 0xFF -> two frames; exactly 3 tx-high cycles between the end of the first stop bit and the second start bit; exactly two pop pulses.
- Reset mid-DATA: assert reset during bit 3 of 0x3C -> tx=1 immediately; after release with fifo_empty=1, no further pop and tx stays 1.
- Parity (macro defined): byte 0x07 -> parity bit 1 after bit 7; byte 0x03 -> parity bit 0; frame is 11 bits x 4 cycles.
